dense_frame_ctrl: RTL and testbench
===================================

// Module: dense_frame_ctrl
// PURPOSE
//  Sequencer for one fully-connected layer. Owns the single-port input-feature BRAM:
//  fills it from the upstream feature stream, then hands the read port to the dense core.
//  Pulses dense start, waits for done, then runs a serial argmax over the core's output
//  vector. Returns the class index to downstream over a valid/ready handshake.
// PARAMETERS
//  DATA_WIDTH  16     feature / output word width, signed
//  IN_DIM      1568   features per frame = BRAM depth
//  OUT_DIM     10     dense outputs = argmax candidates
//  WDOG_CYCLES 2**24  dense-done timeout; used only with DENSE_FRAME_CTRL_WDOG_EN
// PORTS
//  clk          in   1                  clock
//  reset        in   1                  async reset, active-high
//  s_valid      in   1                  upstream feature beat valid
//  s_ready      out  1                  upstream beat accepted when s_valid & s_ready
//  s_data       in   DATA_WIDTH         feature value, signed
//  s_last       in   1                  upstream marks the final beat of the frame
//  bram_en      out  1                  BRAM port enable
//  bram_we      out  1                  BRAM write enable
//  bram_addr    out  clog2(IN_DIM)      BRAM address
//  bram_din     out  DATA_WIDTH         BRAM write data
//  core_addr    in   clog2(IN_DIM)      dense core read address
//  core_en      in   1                  dense core read enable
//  core_start   out  1                  one-cycle start pulse to the dense core
//  core_done    in   1                  one-cycle done pulse from the dense core
//  core_vec     in   DATA_WIDTH x OUT_DIM  dense outputs; stable after core_done
//  m_valid      out  1                  class result valid
//  m_ready      in   1                  downstream accepts the result
//  m_class      out  clog2(OUT_DIM)     argmax index
//  m_score      out  DATA_WIDTH         winning value, signed
//  frame_err    out  1                  sticky: s_last on the wrong beat
//  busy         out  1                  1 in every state except FILL with fill count 0
// BEHAVIOUR
//  Reset: all outputs 0; state FILL; fill count 0. Async assert; release is synchronous to clk.
//  FILL: s_ready=1. On each accepted beat: bram_en=bram_we=1, bram_addr=count, bram_din=s_data
//    combinationally. The count increments.
//   - Beat IN_DIM-1 goes to LAUNCH. s_last on that beat is expected.
//   - s_last on any other beat sets frame_err. That beat is written and the count continues;
//     the frame is never shortened. A missing s_last on beat IN_DIM-1 also sets frame_err.
//  LAUNCH: core_start=1 for exactly 1 cycle -> RUN. s_ready=0 from here until re-entry into FILL.
//  RUN: bram_en=core_en, bram_addr=core_addr, bram_we=0. No added latency; the core's read
//    latency is unchanged. core_done -> ARGMAX. core_en outside RUN is ignored (bram_en not driven
//    by the core).
//  ARGMAX: 1 candidate per cycle, k=0..OUT_DIM-1. That is OUT_DIM cycles.
//   - best initialised to core_vec[0], idx 0.
//   - Strict signed '>' comparison; ties keep the lowest index.
//   - After k=OUT_DIM-1 -> HOLD.
//  HOLD: m_valid=1; m_class and m_score stable until m_valid & m_ready.
//   - Handshake cycle -> FILL with count 0. frame_err clears on entry to FILL.
//   - m_ready already high on HOLD entry -> 1-cycle HOLD.
//  Latency: last beat accepted -> core_start is the next cycle.
//    core_done -> m_valid is OUT_DIM+1 cycles later.
//  Simultaneous events:
//   - core_done in the LAUNCH cycle is ignored.
//   - s_valid outside FILL is not accepted.
//  Reset mid-frame or mid-run: everything is abandoned. core_start is not re-issued;
//    the core is reset by the same reset net.
// CONFIGURATION
//  DENSE_FRAME_CTRL_WDOG_EN defined:
//   - A counter runs in RUN. At WDOG_CYCLES without core_done the block enters HOLD with
//     m_class=0, m_score=0, and sets frame_err.
//   - Any later core_done is ignored until the next LAUNCH.
//  Undefined: no counter is built; RUN waits indefinitely; WDOG_CYCLES is unused.
// TESTING
//  1. IN_DIM=4, OUT_DIM=3: stream 1,2,3,4 with s_last on beat 3 -> bram writes at addr 0..3;
//     core_start the next cycle; frame_err=0.
//  2. core_vec={5,-2,9}, core_done pulse -> m_valid 4 cycles later, m_class=2, m_score=9.
//  3. core_vec={7,7,-1} -> m_class=0 (tie keeps lowest). core_vec={-8,-3,-5} -> m_class=1, m_score=-3.
//  4. s_last on beat 1 of 4 -> frame_err=1. All 4 beats are still written.
//     frame_err clears after the m_ready handshake.
//  5. m_ready low for 5 cycles in HOLD -> outputs stable, s_ready=0. Pulse m_ready -> s_ready=1
//     the next cycle. Drive core_en with s_valid during RUN -> bram_we=0, no s_ready.
//  6. With WDOG_EN and WDOG_CYCLES=16: no core_done -> m_valid at RUN+16, m_class=0,
//     frame_err=1. Assert reset mid-FILL -> count 0, all outputs 0 within the reset cycle.

Source files
------------

// File: rtl/dense_frame_ctrl.sv
// Frame sequencer for one dense layer: BRAM fill, core launch, serial argmax, result handshake.
// Optional dense-done watchdog is built when DENSE_FRAME_CTRL_WDOG_EN is defined.
module dense_frame_ctrl #(
   parameter int DATA_WIDTH  = 16,
   parameter int IN_DIM      = 1568,
   parameter int OUT_DIM     = 10,
   parameter int WDOG_CYCLES = 2**24
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             s_valid,
   output logic                             s_ready,
   input  logic [DATA_WIDTH-1:0]            s_data,
   input  logic                             s_last,
   output logic                             bram_en,
   output logic                             bram_we,
   output logic [$clog2(IN_DIM)-1:0]        bram_addr,
   output logic [DATA_WIDTH-1:0]            bram_din,
   input  logic [$clog2(IN_DIM)-1:0]        core_addr,
   input  logic                             core_en,
   output logic                             core_start,
   input  logic                             core_done,
   input  logic [DATA_WIDTH*OUT_DIM-1:0]    core_vec,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic [$clog2(OUT_DIM)-1:0]       m_class,
   output logic [DATA_WIDTH-1:0]            m_score,
   output logic                             frame_err,
   output logic                             busy
);

   localparam int ADDR_W  = $clog2(IN_DIM);
   localparam int CLASS_W = $clog2(OUT_DIM);

   typedef enum logic [2:0] {FILL, LAUNCH, RUN, ARGMAX, HOLD} state_t;

   state_t                        state, state_nxt;
   logic [ADDR_W-1:0]             fill_cnt;
   logic [CLASS_W-1:0]            cand;
   logic [CLASS_W-1:0]            best_idx;
   logic signed [DATA_WIDTH-1:0]  best_val;
   logic signed [DATA_WIDTH-1:0]  cand_val;
   logic                          accept;
   logic                          last_beat;
   logic                          wdog_fire;

   assign accept    = s_valid && s_ready;
   assign last_beat = (fill_cnt == ADDR_W'(IN_DIM-1));
   assign cand_val  = core_vec[int'(cand)*DATA_WIDTH +: DATA_WIDTH];
   assign m_class   = best_idx;
   assign m_score   = best_val;
   assign busy      = !((state == FILL) && (fill_cnt == '0));

`ifdef DENSE_FRAME_CTRL_WDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYCLES+1);
   logic [WDOG_W-1:0] wdog_cnt;

   // Counts cycles spent in RUN; restarts on every entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wdog_cnt <= '0;
      else if (state != RUN)
         wdog_cnt <= '0;
      else
         wdog_cnt <= wdog_cnt + 1'b1;
   end

   assign wdog_fire = (state == RUN) && !core_done && (wdog_cnt == WDOG_W'(WDOG_CYCLES-1));
`else
   // No timeout in this build; the parameter stays for a uniform interface.
   assign wdog_fire = 1'b0 & (WDOG_CYCLES > 0);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= FILL;
      else
         state <= state_nxt;
   end

   // s_ready is held low while reset is asserted so every output reads 0.
   always_comb begin
      state_nxt  = state;
      s_ready    = 1'b0;
      bram_en    = 1'b0;
      bram_we    = 1'b0;
      bram_addr  = '0;
      bram_din   = '0;
      core_start = 1'b0;
      m_valid    = 1'b0;
      case (state)
         FILL: begin
            s_ready = !reset;
            if (accept) begin
               bram_en   = 1'b1;
               bram_we   = 1'b1;
               bram_addr = fill_cnt;
               bram_din  = s_data;
               if (last_beat)
                  state_nxt = LAUNCH;
            end
         end
         LAUNCH: begin
            core_start = 1'b1;
            state_nxt  = RUN;
         end
         RUN: begin
            bram_en   = core_en;
            bram_addr = core_addr;
            if (core_done)
               state_nxt = ARGMAX;
            else if (wdog_fire)
               state_nxt = HOLD;
         end
         ARGMAX: begin
            if (cand == CLASS_W'(OUT_DIM-1))
               state_nxt = HOLD;
         end
         HOLD: begin
            m_valid = 1'b1;
            if (m_ready)
               state_nxt = FILL;
         end
         default: state_nxt = FILL;
      endcase
   end

   // Candidate 0 seeds the running best; later ones replace it only when strictly larger.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fill_cnt  <= '0;
         cand      <= '0;
         best_idx  <= '0;
         best_val  <= '0;
         frame_err <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (accept) begin
                  fill_cnt <= last_beat ? '0 : fill_cnt + 1'b1;
                  if (last_beat != s_last)
                     frame_err <= 1'b1;
               end
            end
            LAUNCH: cand <= '0;
            RUN: begin
               cand <= '0;
               if (wdog_fire) begin
                  best_idx  <= '0;
                  best_val  <= '0;
                  frame_err <= 1'b1;
               end
            end
            ARGMAX: begin
               cand <= cand + 1'b1;
               if ((cand == '0) || (cand_val > best_val)) begin
                  best_val <= cand_val;
                  best_idx <= cand;
               end
            end
            HOLD: begin
               if (m_ready) begin
                  fill_cnt  <= '0;
                  frame_err <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dense_frame_ctrl.sv
// Bench for dense_frame_ctrl at IN_DIM=4, OUT_DIM=3: per-cycle reference model plus pinned frames.
// The watchdog scenario is exercised only when DENSE_FRAME_CTRL_WDOG_EN is defined.
module tb_dense_frame_ctrl;

   localparam int DW     = 16;
   localparam int IN_DIM = 4;
   localparam int OUT_DIM = 3;
   localparam int WDOG   = 16;
   localparam int VW     = DW*OUT_DIM;

   localparam int PH_FILL   = 0;
   localparam int PH_LAUNCH = 1;
   localparam int PH_RUN    = 2;
   localparam int PH_CALC   = 3;
   localparam int PH_HOLD   = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            s_valid, s_ready, s_last;
   logic [DW-1:0]   s_data;
   logic            bram_en, bram_we;
   logic [1:0]      bram_addr;
   logic [DW-1:0]   bram_din;
   logic [1:0]      core_addr;
   logic            core_en, core_start, core_done;
   logic [VW-1:0]   core_vec;
   logic            m_valid, m_ready;
   logic [1:0]      m_class;
   logic [DW-1:0]   m_score;
   logic            frame_err, busy;

   int compared   = 0;
   int mismatched = 0;

   dense_frame_ctrl #(
      .DATA_WIDTH(DW), .IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .WDOG_CYCLES(WDOG)
   ) dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
      .core_addr(core_addr), .core_en(core_en), .core_start(core_start), .core_done(core_done),
      .core_vec(core_vec),
      .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class), .m_score(m_score),
      .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic logic [VW-1:0] packVec(input int a, input int b, input int c);
      return {16'(c), 16'(b), 16'(a)};
   endfunction

   function automatic int refArgmax(input logic [VW-1:0] v);
      int best = 0;
      for (int i = 1; i < OUT_DIM; i++)
         if ($signed(v[i*DW +: DW]) > $signed(v[best*DW +: DW]))
            best = i;
      return best;
   endfunction

   // Reference model: phase, beats taken, error flag and the result the layer must report.
   int            ph = PH_FILL;
   int            beats = 0;
   int            calc_left = 0;
   int            run_cycles = 0;
   bit            exp_err = 1'b0;
   int            exp_class = 0;
   logic [DW-1:0] exp_score = '0;

   // Compare outputs against the model mid-cycle, then advance it with the inputs the next edge samples.
   always @(negedge clk) begin
      if (reset) begin
         checkOutput("rst_s_ready", s_ready, 0);
         checkOutput("rst_bram_en", bram_en, 0);
         checkOutput("rst_bram_we", bram_we, 0);
         checkOutput("rst_core_start", core_start, 0);
         checkOutput("rst_m_valid", m_valid, 0);
         checkOutput("rst_m_class", m_class, 0);
         checkOutput("rst_m_score", m_score, 0);
         checkOutput("rst_frame_err", frame_err, 0);
         checkOutput("rst_busy", busy, 0);
         ph = PH_FILL; beats = 0; exp_err = 1'b0;
      end else begin
         checkOutput("s_ready", s_ready, ph == PH_FILL);
         checkOutput("core_start", core_start, ph == PH_LAUNCH);
         checkOutput("m_valid", m_valid, ph == PH_HOLD);
         checkOutput("frame_err", frame_err, exp_err);
         checkOutput("busy", busy, !(ph == PH_FILL && beats == 0));
         if (ph == PH_FILL) begin
            checkOutput("fill_bram_en", bram_en, s_valid);
            checkOutput("fill_bram_we", bram_we, s_valid);
            if (s_valid) begin
               checkOutput("fill_bram_addr", bram_addr, beats);
               checkOutput("fill_bram_din", bram_din, s_data);
            end
         end else if (ph == PH_RUN) begin
            checkOutput("run_bram_en", bram_en, core_en);
            checkOutput("run_bram_we", bram_we, 0);
            if (core_en)
               checkOutput("run_bram_addr", bram_addr, core_addr);
         end else begin
            checkOutput("idle_bram_en", bram_en, 0);
            checkOutput("idle_bram_we", bram_we, 0);
         end
         if (ph == PH_HOLD) begin
            checkOutput("hold_m_class", m_class, exp_class);
            checkOutput("hold_m_score", m_score, exp_score);
         end

         case (ph)
            PH_FILL: if (s_valid) begin
               if (s_last != (beats == IN_DIM-1))
                  exp_err = 1'b1;
               beats++;
               if (beats == IN_DIM)
                  ph = PH_LAUNCH;
            end
            PH_LAUNCH: begin
               ph = PH_RUN;
               run_cycles = 0;
            end
            PH_RUN: begin
               run_cycles++;
               if (core_done) begin
                  exp_class = refArgmax(core_vec);
                  exp_score = core_vec[exp_class*DW +: DW];
                  calc_left = OUT_DIM;
                  ph = PH_CALC;
               end
`ifdef DENSE_FRAME_CTRL_WDOG_EN
               else if (run_cycles == WDOG) begin
                  exp_class = 0;
                  exp_score = '0;
                  exp_err   = 1'b1;
                  ph = PH_HOLD;
               end
`endif
            end
            PH_CALC: begin
               calc_left--;
               if (calc_left == 0)
                  ph = PH_HOLD;
            end
            PH_HOLD: if (m_ready) begin
               ph = PH_FILL;
               beats = 0;
               exp_err = 1'b0;
            end
            default: ph = PH_FILL;
         endcase
      end
   end

   task automatic resetPulse();
      @(posedge clk); #1;
      reset = 1'b1;
      s_valid = 1'b0; s_last = 1'b0; core_en = 1'b0; core_done = 1'b0; m_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic streamFrame(input int last_beat, input bit pinned);
      for (int i = 0; i < IN_DIM; i++) begin
         int gap = pinned ? 0 : int'($urandom_range(0, 2));
         repeat (gap) begin @(posedge clk); #1; end
         s_valid = 1'b1;
         s_data  = pinned ? 16'(i+1) : 16'($urandom);
         s_last  = (i == last_beat);
         @(posedge clk); #1;
         s_valid = 1'b0;
         s_last  = 1'b0;
      end
   endtask

   // One full frame; pinned frames also compare against hand-computed results.
   task automatic applyStimulus(input int last_beat, input logic [VW-1:0] vec, input int ready_delay,
                                input bit done_in_launch, input bit pinned, input int lit_class,
                                input logic [DW-1:0] lit_score, input bit lit_err);
      int lat;
      bit seen;
      streamFrame(last_beat, pinned);
      if (done_in_launch) core_done = 1'b1;
      @(negedge clk);
      checkOutput("start_after_last_beat", core_start, 1);
      @(posedge clk); #1;
      core_done = 1'b0;
      repeat ($urandom_range(0, 5)) begin
         core_en   = 1'($urandom);
         core_addr = 2'($urandom_range(0, IN_DIM-1));
         s_valid   = 1'($urandom);
         s_data    = 16'($urandom);
         @(posedge clk); #1;
      end
      core_en = 1'b0; s_valid = 1'b0;
      core_vec  = vec;
      core_done = 1'b1;
      if (ready_delay < 0) m_ready = 1'b1;
      @(posedge clk); #1;
      core_done = 1'b0;
      lat = 0; seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         lat++;
         seen = m_valid;
      end
      if (!seen) begin
         checkOutput("m_valid_timeout", 0, 1);
         resetPulse();
         return;
      end
      checkOutput("done_to_valid_latency", lat, OUT_DIM+1);
      if (pinned) begin
         checkOutput("lit_m_class", m_class, lit_class);
         checkOutput("lit_m_score", m_score, lit_score);
         checkOutput("lit_frame_err", frame_err, lit_err);
      end
      if (ready_delay >= 0) begin
         repeat (ready_delay) begin @(posedge clk); #1; end
         m_ready = 1'b1;
      end
      @(posedge clk); #1;
      m_ready = 1'b0;
      @(negedge clk);
      checkOutput("s_ready_after_handshake", s_ready, 1);
      checkOutput("frame_err_after_handshake", frame_err, 0);
   endtask

   initial begin
      reset = 1'b1;
      s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      core_addr = '0; core_en = 1'b0; core_done = 1'b0; core_vec = '0; m_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkOutput("post_reset_busy", busy, 0);
      checkOutput("post_reset_s_ready", s_ready, 1);

      applyStimulus(3, packVec(5, -2, 9), 0, 1'b0, 1'b1, 2, 16'd9, 1'b0);
      applyStimulus(3, packVec(7, 7, -1), 5, 1'b0, 1'b1, 0, 16'd7, 1'b0);
      applyStimulus(3, packVec(-8, -3, -5), -1, 1'b1, 1'b1, 1, 16'hFFFD, 1'b0);
      applyStimulus(1, packVec(1, 2, 3), 2, 1'b0, 1'b1, 2, 16'd3, 1'b1);
      applyStimulus(-1, packVec(0, 0, 0), 0, 1'b0, 1'b1, 0, 16'd0, 1'b1);

      // Reset in the middle of a frame abandons it.
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = 16'h1234;
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b1;
      #1;
      checkOutput("midfill_rst_s_ready", s_ready, 0);
      checkOutput("midfill_rst_bram_en", bram_en, 0);
      checkOutput("midfill_rst_busy", busy, 0);
      s_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("midfill_after_busy", busy, 0);

      for (int f = 0; f < 30; f++) begin
         int lb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) - 1 : IN_DIM-1;
         logic [VW-1:0] v = packVec(int'($urandom_range(0, 7)) - 4, int'($urandom_range(0, 7)) - 4,
                                    int'($urandom_range(0, 7)) - 4);
         applyStimulus(lb, v, int'($urandom_range(0, 5)) - 1, 1'($urandom), 1'b0, 0, '0, 1'b0);
      end

`ifdef DENSE_FRAME_CTRL_WDOG_EN
      begin
         int lat;
         bit seen;
         streamFrame(IN_DIM-1, 1'b1);
         @(negedge clk);
         checkOutput("wdog_start", core_start, 1);
         lat = 0; seen = 1'b0;
         for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            lat++;
            seen = m_valid;
         end
         checkOutput("wdog_latency", lat, WDOG+1);
         checkOutput("wdog_m_class", m_class, 0);
         checkOutput("wdog_m_score", m_score, 0);
         checkOutput("wdog_frame_err", frame_err, 1);
         @(posedge clk); #1;
         core_done = 1'b1;
         @(posedge clk); #1;
         core_done = 1'b0;
         m_ready = 1'b1;
         @(posedge clk); #1;
         m_ready = 1'b0;
         @(negedge clk);
         checkOutput("wdog_back_to_fill", s_ready, 1);
      end
`endif

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "[TB] stopped");
   end

endmodule
